// File: rtl/ctr_buffer_ctrl_if.sv
// Bundles the record emitter, control and CSR read signals of the
// control-transfer record buffer.
// master: the emitter/CSR side. slave: the buffer controller.
interface ctr_buffer_ctrl_if #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 64
);
  localparam int IW = $clog2(DEPTH);

  // Record emitter
  logic             rec_valid_i;
  logic [XLEN-1:0]  rec_source_i;
  logic [XLEN-1:0]  rec_target_i;
  logic [3:0]       rec_type_i;
  logic [1:0]       rec_priv_i;

  // Recording control
  logic [2:0]       ctr_en_i;
  logic [15:0]      type_inhibit_i;
  logic             freeze_i;
  logic             clr_req_i;
  logic             clr_busy_o;

  // CSR read port
  logic             csr_rd_req_i;
  logic [IW-1:0]    csr_rd_idx_i;
  logic             csr_rd_gnt_o;
  logic             csr_rd_valid_o;
  logic             csr_rd_v_o;
  logic [XLEN-1:0]  csr_rd_source_o;
  logic [XLEN-1:0]  csr_rd_target_o;
  logic [3:0]       csr_rd_type_o;

  // Status
  logic [IW-1:0]    wrptr_o;
  logic             rec_drop_o;

  modport master (
    output rec_valid_i, rec_source_i, rec_target_i, rec_type_i, rec_priv_i,
    output ctr_en_i, type_inhibit_i, freeze_i, clr_req_i,
    output csr_rd_req_i, csr_rd_idx_i,
    input  clr_busy_o, csr_rd_gnt_o, csr_rd_valid_o, csr_rd_v_o,
    input  csr_rd_source_o, csr_rd_target_o, csr_rd_type_o,
    input  wrptr_o, rec_drop_o
  );

  modport slave (
    input  rec_valid_i, rec_source_i, rec_target_i, rec_type_i, rec_priv_i,
    input  ctr_en_i, type_inhibit_i, freeze_i, clr_req_i,
    input  csr_rd_req_i, csr_rd_idx_i,
    output clr_busy_o, csr_rd_gnt_o, csr_rd_valid_o, csr_rd_v_o,
    output csr_rd_source_o, csr_rd_target_o, csr_rd_type_o,
    output wrptr_o, rec_drop_o
  );
endinterface

// File: rtl/ctr_buffer_ctrl.sv
// Control-transfer record buffer controller.
// A circular buffer of DEPTH records {v, source, target, type} with a single
// storage port shared by the clear sequence, CSR reads and record writes.
// A one-entry holding register keeps record order when a CSR read takes the
// port; a second record arriving while the holder is full is dropped.
// Reads are addressed logically (0 = newest) and answer one cycle later.
module ctr_buffer_ctrl #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ctr_buffer_ctrl_if.slave    bus
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage: one access per cycle, no reset, so it maps onto a 1-port SRAM.
  // ---------------------------------------------------------------------------
  logic             mem_v    [DEPTH];
  logic [XLEN-1:0]  mem_src  [DEPTH];
  logic [XLEN-1:0]  mem_tgt  [DEPTH];
  logic [3:0]       mem_type [DEPTH];

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [IW-1:0]    cnt_q;
  logic [IW-1:0]    wrptr_q;
  logic             hold_valid_q;
  logic [XLEN-1:0]  hold_src_q;
  logic [XLEN-1:0]  hold_tgt_q;
  logic [3:0]       hold_type_q;
  logic             drop_q;
  logic             rd_valid_q;

  // Read response registers
  logic             rd_v_q;
  logic [XLEN-1:0]  rd_src_q;
  logic [XLEN-1:0]  rd_tgt_q;
  logic [3:0]       rd_type_q;

  // ---------------------------------------------------------------------------
  // Combinational port arbitration
  // ---------------------------------------------------------------------------
  logic             priv_en_s;
  logic             rec_ok_s;
  logic             rec_take_s;
  logic             rd_gnt_s;
  logic [IW-1:0]    rd_addr_s;

  logic             mem_we_s;
  logic             rd_en_s;
  logic [IW-1:0]    mem_addr_s;
  logic             wd_v_s;
  logic [XLEN-1:0]  wd_src_s;
  logic [XLEN-1:0]  wd_tgt_s;
  logic [3:0]       wd_type_s;

  logic             wr_adv_s;
  logic             hold_load_s;
  logic             hold_drain_s;
  logic             drop_s;

  // Privilege enable lookup; privilege 2 is reserved and never records.
  always_comb begin
    priv_en_s = 1'b0;
    case (bus.rec_priv_i)
      2'd0:    priv_en_s = bus.ctr_en_i[0];
      2'd1:    priv_en_s = bus.ctr_en_i[1];
      2'd3:    priv_en_s = bus.ctr_en_i[2];
      default: priv_en_s = 1'b0;
    endcase
  end

  // A record qualifies only while idle; a clear request in the same cycle
  // swallows it silently.
  assign rec_ok_s = bus.rec_valid_i
                 && (bus.rec_type_i != 4'd0)
                 && priv_en_s
                 && !bus.type_inhibit_i[bus.rec_type_i]
                 && !bus.freeze_i
                 && (state_q == ST_IDLE);
  assign rec_take_s = rec_ok_s && !bus.clr_req_i;

  // Reads are granted whenever idle and never wait on record traffic.
  assign rd_gnt_s  = bus.csr_rd_req_i && (state_q == ST_IDLE);
  // Newest entry sits just behind the write pointer; the pointer used is the
  // registered one, i.e. before any write that could happen this cycle.
  assign rd_addr_s = wrptr_q - IW'(1) - bus.csr_rd_idx_i;

  // Single-port arbitration: clear > read > hold drain > direct write.
  always_comb begin
    mem_we_s     = 1'b0;
    rd_en_s      = 1'b0;
    mem_addr_s   = wrptr_q;
    wd_v_s       = 1'b0;
    wd_src_s     = '0;
    wd_tgt_s     = '0;
    wd_type_s    = 4'd0;
    wr_adv_s     = 1'b0;
    hold_load_s  = 1'b0;
    hold_drain_s = 1'b0;
    drop_s       = 1'b0;

    if (state_q == ST_CLEAR) begin
      // Invalidate one entry per cycle, data cleared with it.
      mem_we_s   = 1'b1;
      mem_addr_s = cnt_q;
    end else if (rd_gnt_s) begin
      // Port taken by the read; a new record parks in the holder or is lost.
      rd_en_s    = 1'b1;
      mem_addr_s = rd_addr_s;
      if (rec_take_s && !hold_valid_q) begin
        hold_load_s = 1'b1;
      end else if (rec_take_s) begin
        drop_s = 1'b1;
      end else begin
        hold_load_s = 1'b0;
      end
    end else if (bus.clr_req_i) begin
      // Clear starts next cycle; nothing is written now.
      mem_we_s = 1'b0;
    end else if (hold_valid_q) begin
      // Older parked record goes first; a new one takes its place.
      mem_we_s    = 1'b1;
      wd_v_s      = 1'b1;
      wd_src_s    = hold_src_q;
      wd_tgt_s    = hold_tgt_q;
      wd_type_s   = hold_type_q;
      wr_adv_s    = 1'b1;
      if (rec_take_s) begin
        hold_load_s = 1'b1;
      end else begin
        hold_drain_s = 1'b1;
      end
    end else if (rec_take_s) begin
      // Free port, empty holder: record lands in the buffer directly.
      mem_we_s  = 1'b1;
      wd_v_s    = 1'b1;
      wd_src_s  = bus.rec_source_i;
      wd_tgt_s  = bus.rec_target_i;
      wd_type_s = bus.rec_type_i;
      wr_adv_s  = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_v[mem_addr_s]    <= wd_v_s;
      mem_src[mem_addr_s]  <= wd_src_s;
      mem_tgt[mem_addr_s]  <= wd_tgt_s;
      mem_type[mem_addr_s] <= wd_type_s;
    end
  end

  // Read response: data of an invalid entry, or of no response, reads as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_v_q    <= 1'b0;
      rd_src_q  <= '0;
      rd_tgt_q  <= '0;
      rd_type_q <= 4'd0;
    end else if (rd_en_s && mem_v[mem_addr_s]) begin
      rd_v_q    <= 1'b1;
      rd_src_q  <= mem_src[mem_addr_s];
      rd_tgt_q  <= mem_tgt[mem_addr_s];
      rd_type_q <= mem_type[mem_addr_s];
    end else begin
      rd_v_q    <= 1'b0;
      rd_src_q  <= '0;
      rd_tgt_q  <= '0;
      rd_type_q <= 4'd0;
    end
  end

  // Clear/idle FSM with write pointer, holding register and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      wrptr_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_src_q   <= '0;
      hold_tgt_q   <= '0;
      hold_type_q  <= 4'd0;
      drop_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rd_valid_q <= rd_gnt_s;
          drop_q     <= drop_s;
          if (bus.clr_req_i) begin
            // Parked record is abandoned silently; the buffer is wiped anyway.
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
          end else begin
            if (wr_adv_s) begin
              wrptr_q <= wrptr_q + IW'(1);
            end
            if (hold_load_s) begin
              hold_valid_q <= 1'b1;
              hold_src_q   <= bus.rec_source_i;
              hold_tgt_q   <= bus.rec_target_i;
              hold_type_q  <= bus.rec_type_i;
            end else if (hold_drain_s) begin
              hold_valid_q <= 1'b0;
            end
          end
        end
        ST_CLEAR: begin
          rd_valid_q <= 1'b0;
          drop_q     <= 1'b0;
          cnt_q      <= cnt_q + IW'(1);
          if (cnt_q == IW'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            wrptr_q <= '0;
          end
        end
        default: begin
          state_q    <= ST_CLEAR;
          cnt_q      <= '0;
          rd_valid_q <= 1'b0;
          drop_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clr_busy_o      = (state_q == ST_CLEAR);
  assign bus.csr_rd_gnt_o    = rd_gnt_s;
  assign bus.csr_rd_valid_o  = rd_valid_q;
  assign bus.csr_rd_v_o      = rd_v_q;
  assign bus.csr_rd_source_o = rd_src_q;
  assign bus.csr_rd_target_o = rd_tgt_q;
  assign bus.csr_rd_type_o   = rd_type_q;
  assign bus.wrptr_o         = wrptr_q;
  assign bus.rec_drop_o      = drop_q;

endmodule

// File: tb/tb_ctr_buffer_ctrl.sv
// Directed scoreboard bench for ctr_buffer_ctrl (DEPTH=16, XLEN=64).
module tb_ctr_buffer_ctrl;
  localparam int DEPTH = 16;
  localparam int XLEN  = 64;

  typedef struct packed {
    logic        v;
    logic [63:0] src;
    logic [63:0] tgt;
    logic [3:0]  typ;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctr_buffer_ctrl_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  ctr_buffer_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  rsp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   drop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] src_of(input int k);
    return 64'(k) << 8;
  endfunction

  function automatic logic [63:0] tgt_of(input int k);
    return 64'h8000_0000 + (64'(k) << 4);
  endfunction

  function automatic rsp_t mk(input logic v, input logic [63:0] s, input logic [63:0] t, input logic [3:0] ty);
    rsp_t r;
    r.v = v; r.src = s; r.tgt = t; r.typ = ty;
    return r;
  endfunction

  function automatic rsp_t rec_rsp(input int k, input logic [3:0] ty);
    return mk(1'b1, src_of(k), tgt_of(k), ty);
  endfunction

  // Monitor: pops the scoreboard on every response and counts drop pulses.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.rec_drop_o) drop_cnt++;
      if (bus.csr_rd_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got response src 0x%0h expected none", bus.csr_rd_source_o);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_v",   64'(bus.csr_rd_v_o),    64'(e.v));
          chk("rsp_src", bus.csr_rd_source_o,    e.src);
          chk("rsp_tgt", bus.csr_rd_target_o,    e.tgt);
          chk("rsp_typ", 64'(bus.csr_rd_type_o), 64'(e.typ));
        end
      end else begin
        chk("idle_data_zero",
            bus.csr_rd_source_o | bus.csr_rd_target_o | 64'(bus.csr_rd_type_o) | 64'(bus.csr_rd_v_o),
            64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input logic v, input logic [1:0] priv, input logic [3:0] ty, input int k);
    bus.rec_valid_i  = v;
    bus.rec_priv_i   = priv;
    bus.rec_type_i   = ty;
    bus.rec_source_i = src_of(k);
    bus.rec_target_i = tgt_of(k);
  endtask

  task automatic no_rec();
    bus.rec_valid_i = 1'b0;
    bus.rec_type_i  = 4'd0;
  endtask

  // Issue a read for this cycle and queue the response it must produce.
  task automatic read_req(input logic [3:0] idx, input rsp_t e);
    bus.csr_rd_req_i = 1'b1;
    bus.csr_rd_idx_i = idx;
    exp_q.push_back(e);
    #1;
    chk("rd_gnt", 64'(bus.csr_rd_gnt_o), 64'd1);
  endtask

  task automatic no_read();
    bus.csr_rd_req_i = 1'b0;
    bus.csr_rd_idx_i = 4'd0;
  endtask

  // Count clock edges until clr_busy_o falls, bounded.
  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (bus.clr_busy_o && n < 64) begin
      tick();
      n++;
    end
    chk(name, 64'(n), 64'd16);
  endtask

  initial begin
    rsp_t zero;
    zero = mk(1'b0, 64'd0, 64'd0, 4'd0);
    bus.rec_valid_i = 1'b0; bus.rec_source_i = 64'd0; bus.rec_target_i = 64'd0;
    bus.rec_type_i = 4'd0; bus.rec_priv_i = 2'd0;
    bus.ctr_en_i = 3'b111; bus.type_inhibit_i = 16'h0000; bus.freeze_i = 1'b0;
    bus.clr_req_i = 1'b0; bus.csr_rd_req_i = 1'b0; bus.csr_rd_idx_i = 4'd0;

    // Reset state and the post-reset clear.
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy",    64'(bus.clr_busy_o),     64'd1);
    chk("rst_wrptr",   64'(bus.wrptr_o),        64'd0);
    chk("rst_rdvalid", 64'(bus.csr_rd_valid_o), 64'd0);
    chk("rst_drop",    64'(bus.rec_drop_o),     64'd0);
    bus.csr_rd_req_i = 1'b1;
    #1;
    chk("rst_gnt_low", 64'(bus.csr_rd_gnt_o), 64'd0);
    bus.csr_rd_req_i = 1'b0;
    rst = 1'b0;
    wait_clear("rst_clear_cycles");
    chk("post_clear_wrptr", 64'(bus.wrptr_o), 64'd0);
    read_req(4'd0, zero); tick(); no_read(); tick();

    // Three S-mode records, read newest and oldest.
    for (int k = 1; k <= 3; k++) begin
      set_rec(1'b1, 2'd1, 4'd1, k); tick();
    end
    no_rec(); tick();
    chk("three_wrptr", 64'(bus.wrptr_o), 64'd3);
    read_req(4'd0, rec_rsp(3, 4'd1)); tick();
    read_req(4'd2, rec_rsp(1, 4'd1)); tick();
    no_read(); tick();

    // Back-to-back reads with records: first parks, second drops.
    read_req(4'd0, rec_rsp(3, 4'd1)); set_rec(1'b1, 2'd1, 4'd1, 4); tick();
    read_req(4'd1, rec_rsp(2, 4'd1)); set_rec(1'b1, 2'd1, 4'd1, 5); tick();
    no_read(); no_rec(); tick(); tick();
    chk("hold_drop_cnt", 64'(drop_cnt),     64'd1);
    chk("hold_wrptr",    64'(bus.wrptr_o),  64'd4);
    read_req(4'd0, rec_rsp(4, 4'd1)); tick();
    read_req(4'd1, rec_rsp(3, 4'd1)); tick();
    no_read(); tick();

    // Drain and reload of the holder in the same cycle keeps order.
    read_req(4'd0, rec_rsp(4, 4'd1)); set_rec(1'b1, 2'd1, 4'd3, 6); tick();
    no_read(); set_rec(1'b1, 2'd1, 4'd7, 7); tick();
    no_rec(); tick();
    chk("reload_wrptr", 64'(bus.wrptr_o), 64'd6);
    read_req(4'd0, rec_rsp(7, 4'd7)); tick();
    read_req(4'd1, rec_rsp(6, 4'd3)); tick();
    read_req(4'd2, rec_rsp(4, 4'd1)); tick();
    no_read(); tick();

    // Filtered records: inhibit, freeze, priv 2, disabled U, type 0.
    bus.type_inhibit_i = 16'h0004; set_rec(1'b1, 2'd1, 4'd2, 8); tick();
    bus.type_inhibit_i = 16'h0000;
    bus.freeze_i = 1'b1; set_rec(1'b1, 2'd1, 4'd1, 9); tick();
    bus.freeze_i = 1'b0;
    set_rec(1'b1, 2'd2, 4'd1, 10); tick();
    bus.ctr_en_i = 3'b110; set_rec(1'b1, 2'd0, 4'd1, 11); tick();
    bus.ctr_en_i = 3'b111; set_rec(1'b1, 2'd1, 4'd0, 12); tick();
    no_rec(); tick();
    chk("filter_wrptr", 64'(bus.wrptr_o), 64'd6);
    chk("filter_drop",  64'(drop_cnt),    64'd1);
    read_req(4'd0, rec_rsp(7, 4'd7)); tick();
    no_read();
    set_rec(1'b1, 2'd3, 4'd5, 13); tick();
    no_rec(); tick();
    chk("mmode_wrptr", 64'(bus.wrptr_o), 64'd7);
    read_req(4'd0, rec_rsp(13, 4'd5)); tick();
    no_read(); tick();

    // Explicit clear, then wrap with 20 records.
    bus.clr_req_i = 1'b1; tick(); bus.clr_req_i = 1'b0;
    wait_clear("clr1_cycles");
    chk("clr1_wrptr", 64'(bus.wrptr_o), 64'd0);
    for (int k = 21; k <= 40; k++) begin
      set_rec(1'b1, 2'd1, 4'((k % 7) + 1), k); tick();
    end
    no_rec(); tick();
    chk("wrap_wrptr", 64'(bus.wrptr_o), 64'd4);
    read_req(4'd15, rec_rsp(25, 4'd5)); tick();
    read_req(4'd0,  rec_rsp(40, 4'd6)); tick();
    no_read(); tick();

    // Clear with a concurrent qualified record, reads blocked meanwhile.
    bus.clr_req_i = 1'b1; set_rec(1'b1, 2'd1, 4'd1, 41); tick();
    bus.clr_req_i = 1'b0; no_rec();
    bus.csr_rd_req_i = 1'b1; #1;
    chk("clear_gnt_low", 64'(bus.csr_rd_gnt_o), 64'd0);
    bus.csr_rd_req_i = 1'b0;
    wait_clear("clr2_cycles");
    chk("clr2_wrptr", 64'(bus.wrptr_o), 64'd0);
    chk("clr2_drop",  64'(drop_cnt),    64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      read_req(4'(i), zero); tick();
    end
    no_read(); tick(); tick();

    // Reset on the cycle of a granted read: response discarded, clear reruns.
    set_rec(1'b1, 2'd1, 4'd1, 50); tick(); no_rec(); tick();
    bus.csr_rd_req_i = 1'b1; bus.csr_rd_idx_i = 4'd0; rst = 1'b1; tick();
    no_read(); rst = 1'b0;
    chk("rst_mid_rdvalid", 64'(bus.csr_rd_valid_o), 64'd0);
    chk("rst_mid_busy",    64'(bus.clr_busy_o),     64'd1);
    wait_clear("rst_mid_cycles");
    chk("rst_mid_wrptr", 64'(bus.wrptr_o), 64'd0);
    read_req(4'd0, zero); tick(); no_read(); tick(); tick();

    chk("rsp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
